muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit, directly downstream of register_file.
- Consumes rs1_dout/rs2_dout as operands and returns a result plus destination index and write strobe for the register-file write port (rd, rd_din, write_enable).
- Radix-2 datapath: shift-add multiply, restoring divide; one bit per cycle. Control core stalls while busy=1.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_sign_fix.sv | 29 ++
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: opcodes, FSM states,
// special-case constants and the divide/multiply short-circuit helper.
package muldiv_pkg;

   localparam int unsigned MD_XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [MD_XLEN-1:0] QUOT_ONES  = '1;
   localparam logic [MD_XLEN-1:0] SIGNED_MIN = {1'b1, {(MD_XLEN-1){1'b0}}};

   typedef struct packed {
      logic               hit;
      logic [MD_XLEN-1:0] value;
   } special_t;

   // Zero-operand multiply, divide by zero and signed overflow have fixed architectural results.
   function automatic special_t special_case(input logic [2:0] f3,
                                             input logic [MD_XLEN-1:0] a,
                                             input logic [MD_XLEN-1:0] b);
      special_t s;
      s.hit   = 1'b0;
      s.value = '0;
      if (!f3[2]) begin
         if (a == '0 || b == '0) s.hit = 1'b1;
      end else if (b == '0) begin
         s.hit   = 1'b1;
         s.value = f3[1] ? a : QUOT_ONES;
      end else if (!f3[0] && a == SIGNED_MIN && b == QUOT_ONES) begin
         s.hit   = 1'b1;
         s.value = f3[1] ? '0 : SIGNED_MIN;
      end
      return s;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control core and muldiv_unit.
interface muldiv_unit_if #(
   parameter int unsigned XLEN = muldiv_pkg::MD_XLEN
);
   logic            start;
   logic            kill;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            wb_enable;

   modport master (
      output start, kill, funct3, op_a, op_b, rd_in,
      input  busy, done, result, rd_out, wb_enable
   );

   modport slave (
      input  start, kill, funct3, op_a, op_b, rd_in,
      output busy, done, result, rd_out, wb_enable
   );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Operand sign analysis: magnitudes for the unsigned datapath plus the result negation flags.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = MD_XLEN
) (
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] mag_a,
   output logic [XLEN-1:0] mag_b,
   output logic            neg_quot,
   output logic            neg_rem,
   output logic            neg_prod
);
   logic a_signed, b_signed, sa, sb;

   always_comb begin
      a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
      b_signed = a_signed && (funct3 != F3_MULHSU);
      sa       = a_signed & op_a[XLEN-1];
      sb       = b_signed & op_b[XLEN-1];
      mag_a    = sa ? -op_a : op_a;
      mag_b    = sb ? -op_b : op_b;
      neg_prod = sa ^ sb;
      neg_quot = sa ^ sb;
      neg_rem  = sa;
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide special cases skip CALC.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = MD_XLEN
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);
   localparam int unsigned   CW   = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] op_a_q, op_b_q, mag_a_q, mag_b_q, hi, lo, result_q;
   logic            neg_quot_q, neg_rem_q, neg_prod_q;
   logic [4:0]      rd_q;
   logic            accept;

   logic [XLEN-1:0] mag_a, mag_b;
   logic            neg_quot, neg_rem, neg_prod;

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .op_a     (bus.op_a),
      .op_b     (bus.op_b),
      .funct3   (bus.funct3),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .neg_quot (neg_quot),
      .neg_rem  (neg_rem),
      .neg_prod (neg_prod)
   );

`ifdef MULDIV_EARLY_OUT_EN
   special_t sp_in;
   assign sp_in = special_case(bus.funct3, bus.op_a, bus.op_b);
`endif

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      if (bus.kill) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: if (bus.start) begin
               accept = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
               state_n = sp_in.hit ? DONE : CALC;
`else
               state_n = CALC;
`endif
            end
            CALC:    if (cnt == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // hi/lo double as product {hi,lo} when multiplying and {remainder, quotient} when dividing.
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [XLEN-1:0]   nxt_hi, nxt_lo, quot, rem, final_res;
   logic [2*XLEN-1:0] prod;
   special_t          sp_q;

   always_comb begin
      mul_sum   = {1'b0, hi} + {1'b0, {XLEN{lo[0]}} & mag_a_q};
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, mag_b_q};
      if (f3_q[2]) begin
         nxt_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
         nxt_lo = {lo[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
         nxt_hi = mul_sum[XLEN:1];
         nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
      end
      prod = {nxt_hi, nxt_lo};
      if (neg_prod_q) prod = -prod;
      quot = neg_quot_q ? -nxt_lo : nxt_lo;
      rem  = neg_rem_q ? -nxt_hi : nxt_hi;
      case (f3_q)
         F3_MUL:                      final_res = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             final_res = quot;
         default:                     final_res = rem;
      endcase
      sp_q = special_case(f3_q, op_a_q, op_b_q);
      if (sp_q.hit) final_res = sp_q.value;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         f3_q       <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         neg_prod_q <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         result_q   <= '0;
         rd_q       <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            cnt        <= '0;
            f3_q       <= bus.funct3;
            op_a_q     <= bus.op_a;
            op_b_q     <= bus.op_b;
            mag_a_q    <= mag_a;
            mag_b_q    <= mag_b;
            neg_quot_q <= neg_quot;
            neg_rem_q  <= neg_rem;
            neg_prod_q <= neg_prod;
            rd_q       <= bus.rd_in;
            hi         <= '0;
            lo         <= bus.funct3[2] ? mag_a : mag_b;
`ifdef MULDIV_EARLY_OUT_EN
            if (sp_in.hit) result_q <= sp_in.value;
`endif
         end else if (state == CALC && !bus.kill) begin
            cnt <= cnt + 1'b1;
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            if (cnt == LAST) result_q <= final_res;
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.result    = result_q;
   assign bus.rd_out    = rd_q;
   assign bus.wb_enable = (state == DONE) && (rd_q != '0);
endmodule
